// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package reg_wb_arbiter_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int X0     = 0;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grants are combinational, last_grant is registered.
module rr_arb2
    import reg_wb_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    grant_e last_grant;

    // Grants depend only on requests and history, never on the grants themselves.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (req_a && (!req_b || last_grant == GNT_B)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GNT_B;
        end else if (gnt_a) begin
            last_grant <= GNT_A;
        end else if (gnt_b) begin
            last_grant <= GNT_B;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the reg_file write port between ALU (a) and load (b) write-back,
// with one output register stage, x0 suppression and read-port forwarding.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = reg_wb_arbiter_pkg::DATA_W,
    parameter int ADDR_W = reg_wb_arbiter_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              reg_wrt_en,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] rs_1,
    input  logic [ADDR_W-1:0] rs_2,
    output logic              fwd_1_hit,
    output logic              fwd_2_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [ADDR_W-1:0] X0_IDX = ADDR_W'(X0);

    logic stall_evt;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_a (a_valid),
        .req_b (b_valid),
        .gnt_a (a_ready),
        .gnt_b (b_ready)
    );

    assign stall_evt = (a_valid && !a_ready) || (b_valid && !b_ready);

    // An x0 transfer still completes the handshake; only the write enable is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wrt_en <= 1'b0;
            rd         <= '0;
            rd_data    <= '0;
            stall_cnt  <= '0;
        end else begin
            reg_wrt_en <= 1'b0;
            if (a_ready) begin
                rd         <= a_rd;
                rd_data    <= a_data;
                reg_wrt_en <= (a_rd != X0_IDX);
            end else if (b_ready) begin
                rd         <= b_rd;
                rd_data    <= b_data;
                reg_wrt_en <= (b_rd != X0_IDX);
            end
            if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // reg_file commits at end of cycle, so same-cycle readers need the bypass.
    assign fwd_1_hit = reg_wrt_en && (rd == rs_1) && (rs_1 != X0_IDX);
    assign fwd_2_hit = reg_wrt_en && (rd == rs_2) && (rs_2 != X0_IDX);
    assign fwd_data  = rd_data;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: directed scenarios followed by random traffic.
module tb_reg_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_rd, b_rd;
    logic [DW-1:0] a_data, b_data;
    logic          reg_wrt_en;
    logic [AW-1:0] rd;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rs_1, rs_2;
    logic          fwd_1_hit, fwd_2_hit;
    logic [DW-1:0] fwd_data;
    logic [CW-1:0] stall_cnt;

    reg_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .reg_wrt_en(reg_wrt_en), .rd(rd), .rd_data(rd_data),
        .rs_1(rs_1), .rs_2(rs_2),
        .fwd_1_hit(fwd_1_hit), .fwd_2_hit(fwd_2_hit), .fwd_data(fwd_data),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          wen;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        int            stall;
    } exp_t;

    exp_t q[$];

    // Reference model: who should win, what the write port shows next, refused-cycle count.
    bit            m_last_b = 1'b1;
    logic          m_wen    = 1'b0;
    logic [AW-1:0] m_rd     = '0;
    logic [DW-1:0] m_data   = '0;
    int            m_stall  = 0;

    function automatic bit win_a(input bit rst_v, input bit va, input bit vb, input bit last_b);
        return !rst_v && va && (!vb || last_b);
    endfunction

    function automatic bit win_b(input bit rst_v, input bit va, input bit vb, input bit last_b);
        return !rst_v && vb && (!va || !last_b);
    endfunction

    always @(posedge clk) begin
        exp_t e;
        bit ga, gb;
        if (rst) begin
            m_last_b = 1'b1;
            m_wen    = 1'b0;
            m_rd     = '0;
            m_data   = '0;
            m_stall  = 0;
        end else begin
            ga = win_a(1'b0, a_valid, b_valid, m_last_b);
            gb = win_b(1'b0, a_valid, b_valid, m_last_b);
            m_wen = 1'b0;
            if (ga) begin
                m_rd = a_rd; m_data = a_data; m_wen = (a_rd != 0); m_last_b = 1'b0;
            end else if (gb) begin
                m_rd = b_rd; m_data = b_data; m_wen = (b_rd != 0); m_last_b = 1'b1;
            end
            if (((a_valid && !ga) || (b_valid && !gb)) && m_stall < CMAX) m_stall++;
        end
        e.wen = m_wen; e.rd = m_rd; e.data = m_data; e.stall = m_stall;
        q.push_back(e);
    end

    // Monitor: compares DUT outputs against the oldest expected record.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("reg_wrt_en", 32'(reg_wrt_en), 32'(e.wen));
            chk("rd", 32'(rd), 32'(e.rd));
            chk("rd_data", rd_data, e.data);
            chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
            chk("fwd_1_hit", 32'(fwd_1_hit), 32'(e.wen && e.rd == rs_1 && rs_1 != 0));
            chk("fwd_2_hit", 32'(fwd_2_hit), 32'(e.wen && e.rd == rs_2 && rs_2 != 0));
            chk("fwd_data", fwd_data, e.data);
        end
        chk("a_ready", 32'(a_ready), 32'(win_a(rst, a_valid, b_valid, m_last_b)));
        chk("b_ready", 32'(b_ready), 32'(win_b(rst, a_valid, b_valid, m_last_b)));
    end

    bit a_took, b_took;

    task automatic step();
        @(negedge clk);
        a_took = a_valid && a_ready;
        b_took = b_valid && b_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        rs_1 = '0; rs_2 = '0;
        step(); step();
        chk("reset_wen", 32'(reg_wrt_en), 32'd0);
        chk("reset_stall", 32'(stall_cnt), 32'd0);
        rst = 1'b0;

        // single ALU write
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h4000_00CD;
        #1 chk("t1_a_ready", 32'(a_ready), 32'd1);
        step();
        a_valid = 1'b0;
        chk("t1_wen", 32'(reg_wrt_en), 32'd1);
        chk("t1_rd", 32'(rd), 32'd5);
        chk("t1_data", rd_data, 32'h4000_00CD);
        chk("t1_stall", 32'(stall_cnt), 32'd0);

        // contention from reset priority: A,B,A,B
        rst = 1'b1; step(); rst = 1'b0;
        a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h11;
        b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_rd_seq", 32'(rd), (i % 2 == 0) ? 32'd2 : 32'd3);
        end
        chk("t2_stall", 32'(stall_cnt), 32'd4);
        a_valid = 1'b0; b_valid = 1'b0;

        // x0 write is accepted but suppressed
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h4000_00CD; rs_1 = 5'd0;
        step();
        a_valid = 1'b0;
        chk("t3_took", 32'(a_took), 32'd1);
        chk("t3_wen", 32'(reg_wrt_en), 32'd0);
        chk("t3_fwd1", 32'(fwd_1_hit), 32'd0);

        // forwarding on port 2 only
        a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h4000_00CF; rs_1 = 5'd0; rs_2 = 5'd2;
        step();
        a_valid = 1'b0;
        chk("t4_fwd2", 32'(fwd_2_hit), 32'd1);
        chk("t4_fwd1", 32'(fwd_1_hit), 32'd0);
        chk("t4_fwd_data", fwd_data, 32'h4000_00CF);

        // reset right after a transfer
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'hDEAD_0007;
        step();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("t5_a_ready_rst", 32'(a_ready), 32'd0);
        chk("t5_b_ready_rst", 32'(b_ready), 32'd0);
        step();
        chk("t5_wen", 32'(reg_wrt_en), 32'd0);
        chk("t5_rd", 32'(rd), 32'd0);
        chk("t5_stall", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        #1;
        chk("t5_a_first", 32'(a_ready), 32'd1);
        chk("t5_b_wait", 32'(b_ready), 32'd0);

        // sustained contention saturates the counter
        for (int i = 0; i < 21; i++) step();
        chk("t6_stall_sat", 32'(stall_cnt), 32'(CMAX));
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;

        // random traffic obeying the hold-until-accepted rule
        a_took = 1'b0; b_took = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (!a_valid || a_took) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_rd = AW'($urandom_range(0, 7));
                a_data = $urandom;
            end
            if (!b_valid || b_took) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_rd = AW'($urandom_range(0, 7));
                b_data = $urandom;
            end
            rs_1 = AW'($urandom_range(0, 7));
            rs_2 = AW'($urandom_range(0, 7));
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
